addr8u_tmr_sequencer: RTL

- Time-redundant controller that shares one external combinational 8-bit unsigned adder (A[7:0] + B[7:0] -> S[8:0]) between two requesters.
- Each accepted request is run through the adder in three passes: (a,b), then (b,a) with operands swapped, then (a,b) again. The result is a bitwise majority vote of the three sums, with a fault flag raised on any disagreement.
- Sits between client logic and the adder instance. It masks single transient adder faults and counts them.

---
 rtl/addr8u_tmr_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/addr8u_tmr_sequencer.sv
// Time-redundant front end for a shared 8-bit adder. Each request is run through the adder
// three times as (a,b), (b,a), (a,b). The three sums are majority-voted, and any disagreement is flagged and counted.
//
// state | meaning
// IDLE  | arbitrate between requesters, accept one
// P0    | adder sees (a,b) for ADD_LAT cycles
// P1    | adder sees (b,a) for ADD_LAT cycles
// P2    | adder sees (a,b) for ADD_LAT cycles
// VOTE  | bitwise majority of the three sums
// RESP  | hold response until consumer takes it
module addr8u_tmr_sequencer #(
    parameter int ADD_LAT = 1,
    parameter int FCNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [7:0]        req0_a_i,
    input  logic [7:0]        req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [7:0]        req1_a_i,
    input  logic [7:0]        req1_b_i,
    output logic [7:0]        add_a_o,
    output logic [7:0]        add_b_o,
    input  logic [8:0]        add_s_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [8:0]        rsp_sum_o,
    output logic              rsp_id_o,
    output logic              rsp_fault_o,
    input  logic              fcnt_clr_i,
    output logic [FCNT_W-1:0] fault_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_VOTE, S_RESP
    } state_t;

    localparam int                CNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ADD_LAT - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic [7:0]        op_a_q, op_a_d, op_b_q, op_b_d;
    logic              id_q, id_d;
    logic [7:0]        add_a_q, add_a_d, add_b_q, add_b_d;
    logic [8:0]        s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [8:0]        rsp_sum_q, rsp_sum_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic              grant_id;
    logic              accept;
    logic              pass_done;
    logic              in_pass;
    logic              hshake;
    logic [7:0]        sel_a, sel_b;

    // With both requesters valid the round-robin pointer decides; otherwise the lone valid wins.
    assign grant_id  = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
    assign accept    = req0_ready_o | req1_ready_o;
    assign sel_a     = grant_id ? req1_a_i : req0_a_i;
    assign sel_b     = grant_id ? req1_b_i : req0_b_i;
    assign in_pass   = (state_q == S_P0) || (state_q == S_P1) || (state_q == S_P2);
    assign pass_done = (cnt_q == '0);
    assign hshake    = (state_q == S_RESP) && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)      state_d = S_P0;
            S_P0:    if (pass_done)   state_d = S_P1;
            S_P1:    if (pass_done)   state_d = S_P2;
            S_P2:    if (pass_done)   state_d = S_VOTE;
            S_VOTE:                   state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Ready is forced low while reset is asserted, even though the state register already reads IDLE.
    always_comb begin
        req0_ready_o = rst_n_i && (state_q == S_IDLE) && req0_valid_i && !grant_id;
        req1_ready_o = rst_n_i && (state_q == S_IDLE) && req1_valid_i && grant_id;
        rsp_valid_o  = (state_q == S_RESP);
    end

    always_comb begin
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_fault_d = rsp_fault_q;
        if (in_pass && !pass_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    id_d    = grant_id;
                    rr_d    = !grant_id;
                    add_a_d = sel_a;
                    add_b_d = sel_b;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_P0: begin
                if (pass_done) begin
                    s0_d    = add_s_i;
                    add_a_d = op_b_q;
                    add_b_d = op_a_q;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_P1: begin
                if (pass_done) begin
                    s1_d    = add_s_i;
                    add_a_d = op_a_q;
                    add_b_d = op_b_q;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_P2: begin
                if (pass_done) begin
                    s2_d    = add_s_i;
                    add_a_d = 8'h00;
                    add_b_d = 8'h00;
                end
            end
            S_VOTE: begin
                rsp_sum_d   = (s0_q & s1_q) | (s1_q & s2_q) | (s0_q & s2_q);
                rsp_fault_d = !((s0_q == s1_q) && (s1_q == s2_q));
                rsp_id_d    = id_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (fcnt_clr_i) begin
            fcnt_d = '0;
        end else if (hshake && rsp_fault_q && (fcnt_q != FCNT_MAX)) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            id_q        <= 1'b0;
            add_a_q     <= 8'h00;
            add_b_q     <= 8'h00;
            s0_q        <= 9'h000;
            s1_q        <= 9'h000;
            s2_q        <= 9'h000;
            rsp_sum_q   <= 9'h000;
            rsp_id_q    <= 1'b0;
            rsp_fault_q <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_fault_q <= rsp_fault_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign add_a_o       = add_a_q;
    assign add_b_o       = add_b_q;
    assign rsp_sum_o     = rsp_sum_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_fault_o   = rsp_fault_q;
    assign fault_count_o = fcnt_q;

endmodule
